// File: rtl/crc10_pkg.sv
// crc10_pkg: shared CRC-10 constants, FSM state type and one-bit register update
package crc10_pkg;
   localparam int CRC_W = 10;
   localparam logic [CRC_W-1:0] POLY_DEFAULT = 10'h233;

   typedef enum logic [1:0] {IDLE, BODY, RESULT} state_t;

   function automatic logic [CRC_W-1:0] crc10_step(input logic [CRC_W-1:0] crc, input logic d,
                                                  input logic [CRC_W-1:0] poly);
      return {crc[CRC_W-2:0], d} ^ (crc[CRC_W-1] ? poly : '0);
   endfunction
endpackage

// File: rtl/crc10_word_step.sv
// crc10_word_step: one full data word of serial CRC-10 steps, word MSB first
module crc10_word_step import crc10_pkg::*; #(
   parameter int               DATA_W = 32,
   parameter logic [CRC_W-1:0] POLY   = POLY_DEFAULT
) (
   input  logic [CRC_W-1:0]  crc,
   input  logic [DATA_W-1:0] word,
   output logic [CRC_W-1:0]  next_crc
);
   // Shift the word in bit by bit, highest bit first, exactly like the generator
   always_comb begin
      next_crc = crc;
      for (int i = DATA_W - 1; i >= 0; i--) next_crc = crc10_step(next_crc, word[i], POLY);
   end
endmodule

// File: rtl/crc10_frame_checker.sv
// crc10_frame_checker: recomputes CRC-10 over frame payload and checks it against the trailer
module crc10_frame_checker import crc10_pkg::*; #(
   parameter int               DATA_W    = 32,
   parameter int               CRC_W     = crc10_pkg::CRC_W,
   parameter logic [CRC_W-1:0] POLY      = POLY_DEFAULT,
   parameter int               MAX_WORDS = 256,
   parameter int               CNT_W     = 16
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic              CRC_Clr,
   input  logic [DATA_W-1:0] Data_In,
   input  logic              Data_Valid,
   input  logic              Data_Sop,
   input  logic              Data_Eop,
   output logic              Data_Ready,
   output logic              Frame_Done,
   output logic              CRC_Ok,
   output logic              CRC_Err,
   output logic              Len_Err,
   output logic              Frame_Abort,
   output logic [CRC_W-1:0]  Calc_Crc,
   output logic [CRC_W-1:0]  Rx_Crc,
   output logic [CNT_W-1:0]  Err_Count
);
   localparam int LEN_W = $clog2(MAX_WORDS + 2);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_WORDS);

   state_t           state;
   logic             up, take, bad_len, bad_crc;
   logic             done_q, ok_q, crc_err_q, len_err_q;
   logic [LEN_W-1:0] count;
   logic [CRC_W-1:0] r, next_r, calc, rx;

   // Only Sop words or words inside a frame are ever taken; stray words in IDLE are dropped
   assign Data_Ready = up && state != RESULT && !CRC_Clr;
   assign take       = Data_Valid && Data_Ready && (Data_Sop || state == BODY);
   assign calc       = Data_Sop ? '0 : r;
   assign rx         = Data_In[CRC_W-1:0];
   assign bad_len    = Data_Sop || count == '0 || count > LEN_MAX;
   assign bad_crc    = rx != calc;
   // A clear arriving during RESULT hides the pulses already on the outputs
   assign Frame_Done = done_q && !CRC_Clr;
   assign CRC_Ok     = ok_q && !CRC_Clr;
   assign CRC_Err    = crc_err_q && !CRC_Clr;
   assign Len_Err    = len_err_q && !CRC_Clr;

   crc10_word_step #(.DATA_W(DATA_W), .POLY(POLY)) u_step (
      .crc(calc),
      .word(Data_In),
      .next_crc(next_r)
   );

   // Frame FSM, CRC register, result capture and saturating error count
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= IDLE;
         up          <= 1'b0;
         count       <= '0;
         r           <= '0;
         Calc_Crc    <= '0;
         Rx_Crc      <= '0;
         Err_Count   <= '0;
         done_q      <= 1'b0;
         ok_q        <= 1'b0;
         crc_err_q   <= 1'b0;
         len_err_q   <= 1'b0;
         Frame_Abort <= 1'b0;
      end else begin
         up          <= 1'b1;
         done_q      <= 1'b0;
         ok_q        <= 1'b0;
         crc_err_q   <= 1'b0;
         len_err_q   <= 1'b0;
         Frame_Abort <= state == BODY && (CRC_Clr || (take && Data_Sop));
         if (CRC_Clr) begin
            state     <= IDLE;
            count     <= '0;
            r         <= '0;
            Err_Count <= '0;
         end else if (take && Data_Eop) begin
            state     <= RESULT;
            Calc_Crc  <= calc;
            Rx_Crc    <= rx;
            done_q    <= 1'b1;
            len_err_q <= bad_len;
            crc_err_q <= bad_crc;
            ok_q      <= !bad_len && !bad_crc;
         end else if (take) begin
            state <= BODY;
            r     <= next_r;
            count <= Data_Sop ? LEN_W'(1) : count + LEN_W'(count <= LEN_MAX);
         end else if (state == RESULT) begin
            state <= IDLE;
            if ((crc_err_q || len_err_q) && Err_Count != '1) Err_Count <= Err_Count + CNT_W'(1);
         end
      end
   end
endmodule
